// File: rtl/byte_packer.sv
// Packs a valid/ready byte stream into little-endian 32-bit words for a FIFO write port.
// in_last closes a partial word early; unused upper lanes are filled with PAD.
module byte_packer #(
  parameter logic [7:0] PAD   = 8'h00,
  parameter int         CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  input  logic             full,
  output logic             write_en,
  output logic [31:0]      data_in,
  output logic [CNT_W-1:0] words_written
);

  logic [23:0]      asm_reg;
  logic [23:0]      asm_next;
  logic [1:0]       lane_reg;
  logic             pending_reg;
  logic [31:0]      data_reg;
  logic [31:0]      word_next;
  logic [CNT_W-1:0] cnt_reg;
  logic             accept;
  logic             complete;

  // Gating with reset keeps a held word from reaching the FIFO in the reset cycle.
  assign write_en      = reset && pending_reg && !full;
  assign in_ready      = reset && (!pending_reg || !full);
  assign accept        = in_valid && in_ready;
  assign complete      = accept && (in_last || (lane_reg == 2'd3));
  assign data_in       = data_reg;
  assign words_written = cnt_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      if (gi < 3) begin : g_asm
        assign word_next[gi*8 +: 8] = (lane_reg > 2'(gi))  ? asm_reg[gi*8 +: 8] :
                                      (lane_reg == 2'(gi)) ? in_data : PAD;
        assign asm_next[gi*8 +: 8]  = (accept && (lane_reg == 2'(gi))) ? in_data
                                                                        : asm_reg[gi*8 +: 8];
      end else begin : g_top
        // Lane 3 is never stored: a byte landing there always completes the word.
        assign word_next[31:24] = (lane_reg == 2'd3) ? in_data : PAD;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      asm_reg     <= '0;
      lane_reg    <= '0;
      pending_reg <= 1'b0;
      data_reg    <= '0;
      cnt_reg     <= '0;
    end else begin
      if (write_en) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
      if (complete) begin
        data_reg    <= word_next;
        pending_reg <= 1'b1;
        lane_reg    <= '0;
        asm_reg     <= '0;
      end else begin
        if (accept) begin
          asm_reg  <= asm_next;
          lane_reg <= lane_reg + 2'd1;
        end
        if (write_en) begin
          pending_reg <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_byte_packer.sv
// Randomised and directed stimulus for byte_packer with a queue scoreboard and a
// byte-list reference model; a second instance covers a narrow counter and non-zero PAD.
module tb_byte_packer;

  logic        clk;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        full;
  logic        in_ready1, in_ready2;
  logic        write_en1, write_en2;
  logic [31:0] data_in1, data_in2;
  logic [15:0] ww1;
  logic [1:0]  ww2;

  byte_packer u_dut1 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready1), .full(full),
    .write_en(write_en1), .data_in(data_in1), .words_written(ww1)
  );

  byte_packer #(.PAD(8'hA5), .CNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready2), .full(full),
    .write_en(write_en2), .data_in(data_in2), .words_written(ww2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_cnt = 0;
  logic [31:0] q1[$];
  logic [31:0] q2[$];
  logic [7:0]  cur[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: collect accepted bytes, emit a word every 4 bytes or at in_last.
  task automatic model_push(input logic [7:0] d, input bit l);
    logic [31:0] w1, w2;
    cur.push_back(d);
    if (cur.size() == 4 || l) begin
      w1 = '0;
      w2 = '0;
      for (int i = 0; i < 4; i++) begin
        w1[i*8 +: 8] = (i < cur.size()) ? cur[i] : 8'h00;
        w2[i*8 +: 8] = (i < cur.size()) ? cur[i] : 8'hA5;
      end
      q1.push_back(w1);
      q2.push_back(w2);
      $display("push word %h (pad A5: %h)", w1, w2);
      cur.delete();
    end
  endtask

  // Called just after a rising edge: drive, check at the falling edge, advance.
  task automatic cycle(input bit r, input bit v, input logic [7:0] d, input bit l,
                       input bit f, input int exp_we, input int exp_rdy);
    reset    = r;
    in_valid = v;
    in_data  = d;
    in_last  = l;
    full     = f;
    @(negedge clk);
    if (exp_we >= 0)  check("write_en_timing", {31'b0, write_en1}, exp_we[31:0]);
    if (exp_rdy >= 0) check("in_ready_value", {31'b0, in_ready1}, exp_rdy[31:0]);
    if (!reset) cur.delete();
    else if (in_valid && in_ready1) model_push(d, l);
    @(posedge clk);
    #1;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      check("we_in_reset", {30'b0, write_en2, write_en1}, 32'd0);
      check("rdy_in_reset", {30'b0, in_ready2, in_ready1}, 32'd0);
      q1.delete();
      q2.delete();
      exp_cnt = 0;
    end else begin
      check("words_written", {16'b0, ww1}, {16'b0, exp_cnt[15:0]});
      check("words_written_w2", {30'b0, ww2}, {30'b0, exp_cnt[1:0]});
      if (full) check("we_while_full", {30'b0, write_en2, write_en1}, 32'd0);
      else      check("rdy_not_full", {30'b0, in_ready2, in_ready1}, 32'd3);
      if (write_en1) begin
        if (q1.size() == 0) check("spurious_write", 32'd1, 32'd0);
        else check("data_in", data_in1, q1.pop_front());
        $display("write %h count %0d", data_in1, exp_cnt + 1);
        exp_cnt++;
      end
      if (write_en2) begin
        if (q2.size() == 0) check("spurious_write_w2", 32'd1, 32'd0);
        else check("data_in_w2", data_in2, q2.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; full = 1'b0;
    @(posedge clk);
    #1;
    cycle(0, 0, 8'h00, 0, 0, 0, 0);
    cycle(0, 0, 8'h00, 0, 0, 0, 0);
    cycle(1, 0, 8'h00, 0, 0, 0, 1);
    check("data_in_after_reset", data_in1, 32'h0);
    check("count_after_reset", {16'b0, ww1}, 32'h0);

    // Four bytes, single write one clock after the 4th
    cycle(1, 1, 8'h11, 0, 0, 0, 1);
    cycle(1, 1, 8'h22, 0, 0, 0, 1);
    cycle(1, 1, 8'h33, 0, 0, 0, 1);
    cycle(1, 1, 8'h44, 0, 0, 0, 1);
    cycle(1, 0, 8'h00, 0, 0, 1, 1);
    cycle(1, 0, 8'h00, 0, 0, 0, 1);

    // Partial word closed by in_last
    cycle(1, 1, 8'hAA, 0, 0, 0, 1);
    cycle(1, 1, 8'hBB, 0, 0, 0, 1);
    cycle(1, 1, 8'hCC, 1, 0, 0, 1);
    cycle(1, 0, 8'h00, 0, 0, 1, 1);

    // Back-to-back bytes: writes 4 clocks apart
    for (int i = 1; i <= 8; i++)
      cycle(1, 1, 8'(i), 0, 0, (i == 5) ? 1 : 0, 1);
    cycle(1, 0, 8'h00, 0, 0, 1, 1);

    // Stall with a pending word
    cycle(1, 1, 8'h12, 0, 0, 0, 1);
    cycle(1, 1, 8'h34, 0, 0, 0, 1);
    cycle(1, 1, 8'h56, 0, 0, 0, 1);
    cycle(1, 1, 8'h78, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 1, 8'h9A, 0, 1, 0, 0);
      check("data_in_stall", data_in1, 32'h78563412);
    end
    cycle(1, 1, 8'h9A, 0, 0, 1, 1);

    // Reset mid-word discards the partial assembly
    cycle(1, 1, 8'h01, 0, 0, 0, 1);
    cycle(1, 1, 8'h02, 0, 0, 0, 1);
    cycle(0, 1, 8'h03, 0, 0, 0, 0);
    cycle(1, 1, 8'h55, 0, 0, 0, 1);
    cycle(1, 1, 8'h66, 0, 0, 0, 1);
    cycle(1, 1, 8'h77, 0, 0, 0, 1);
    cycle(1, 1, 8'h88, 0, 0, 0, 1);
    cycle(1, 0, 8'h00, 0, 0, 1, 1);
    cycle(1, 0, 8'h00, 0, 0, 0, 1);
    check("count_after_reset_word", {16'b0, ww1}, 32'd1);

    // Randomised traffic with back-pressure and occasional reset
    for (int i = 0; i < 2000; i++) begin
      cycle(($urandom_range(0, 299) != 0), ($urandom_range(0, 3) != 0),
            8'($urandom), ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0), -1, -1);
    end

    // Drain any outstanding words, bounded
    for (int i = 0; i < 20 && (q1.size() != 0 || q2.size() != 0); i++)
      cycle(1, 0, 8'h00, 0, 0, -1, -1);
    check("queue_drained", q1.size(), 32'd0);
    check("queue_drained_w2", q2.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
